// File: rtl/cf_math_pkg.sv
// Shared width helpers used by the arbiter family and other index-producing blocks.
package cf_math_pkg;

    // Index width that never collapses to zero, so a single requester still gets a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 1) ? $clog2(num_idx) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_find_first.sv
// Combinational round-robin search: first set request at or after start_i, wrapping past NumIn-1.
module rr_arb_find_first
    import cf_math_pkg::*;
#(
    parameter int unsigned NumIn    = 4,
    parameter int unsigned IdxWidth = idx_width(NumIn)
) (
    input  logic [NumIn-1:0]    req_i,
    input  logic [IdxWidth-1:0] start_i,
    output logic                valid_o,
    output logic [IdxWidth-1:0] idx_o
);

    logic [2*NumIn-1:0] dbl_req;
    logic [IdxWidth:0]  pos;

    always_comb begin
        // Lower copy keeps only bits at or above start; upper copy supplies the wrapped tail.
        dbl_req = '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            dbl_req[i]         = req_i[i] & (i >= int'(start_i));
            dbl_req[i + NumIn] = req_i[i];
        end

        pos = '0;
        for (int i = 2 * int'(NumIn) - 1; i >= 0; i--) begin
            if (dbl_req[i]) begin
                pos = (IdxWidth + 1)'(i);
            end
        end

        valid_o = |req_i;
        if (pos >= (IdxWidth + 1)'(NumIn)) begin
            idx_o = IdxWidth'(pos - (IdxWidth + 1)'(NumIn));
        end else begin
            idx_o = pos[IdxWidth-1:0];
        end
    end

endmodule

// File: rtl/rr_req_arbiter.sv
// Flat round-robin arbiter: zero-latency select of one requester onto a shared req/gnt port.
module rr_req_arbiter
    import cf_math_pkg::*;
#(
    parameter int unsigned NumIn     = 4,
    parameter int unsigned DataWidth = 32,
    parameter bit          LockIn    = 1'b1,
    parameter int unsigned IdxWidth  = idx_width(NumIn)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic [NumIn-1:0]             req_i,
    output logic [NumIn-1:0]             gnt_o,
    input  logic [NumIn*DataWidth-1:0]   data_i,
    output logic                         req_o,
    input  logic                         gnt_i,
    output logic [DataWidth-1:0]         data_o,
    output logic [IdxWidth-1:0]          idx_o
);

    typedef logic [IdxWidth-1:0] idx_t;

    localparam idx_t LastIdx = idx_t'(NumIn - 1);

    idx_t rr_q, rr_d;
    idx_t lock_idx_q, lock_idx_d;
    logic lock_q, lock_d;
    idx_t ff_idx;
    logic ff_valid;
    logic lock_live;
    idx_t sel;
    logic xfer;

    rr_arb_find_first #(
        .NumIn    (NumIn),
        .IdxWidth (IdxWidth)
    ) u_find_first (
        .req_i   (req_i),
        .start_i (rr_q),
        .valid_o (ff_valid),
        .idx_o   (ff_idx)
    );

    always_comb begin
        // A lock whose request vanished is ignored so the port falls back to a normal search.
        lock_live = lock_q & req_i[lock_idx_q];
        sel       = lock_live ? lock_idx_q : ff_idx;

        req_o  = ff_valid;
        idx_o  = req_o ? sel : '0;
        data_o = req_o ? data_i[int'(idx_o)*DataWidth +: DataWidth] : '0;
        for (int i = 0; i < int'(NumIn); i++) begin
            gnt_o[i] = gnt_i & req_o & (idx_o == idx_t'(i));
        end
        xfer = req_o & gnt_i;
    end

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (flush_i) begin
            rr_d       = '0;
            lock_d     = 1'b0;
            lock_idx_d = '0;
        end else if (xfer) begin
            rr_d   = (idx_o == LastIdx) ? '0 : idx_o + idx_t'(1);
            lock_d = 1'b0;
        end else if (LockIn && req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = idx_o;
        end else begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifndef SYNTHESIS
    // Handshake: a requester raises req_i with stable data_i and holds both until its gnt_o
    // pulses; a transfer happens on any cycle with req_o and gnt_i both high.
    locked_req_held_a: assert property (
        @(posedge clk) disable iff (!rst_n || flush_i) lock_q |-> req_i[lock_idx_q]
    );
    grant_onehot_a: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(gnt_o)
    );
`endif

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter: locking 4-input, non-locking 4-input and 3-input instances.
module tb_rr_req_arbiter;

    logic clk;
    logic rst_n;
    logic flush_a, flush_b, flush_c;
    logic [3:0] req_a, req_b;
    logic [2:0] req_c;
    logic gnt_a, gnt_b, gnt_c;
    logic [127:0] data_ab;
    logic [95:0]  data_c;

    logic [3:0]  a_gnt_o, b_gnt_o;
    logic [2:0]  c_gnt_o;
    logic        a_req_o, b_req_o, c_req_o;
    logic [31:0] a_data_o, b_data_o, c_data_o;
    logic [1:0]  a_idx_o, b_idx_o, c_idx_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rr_req_arbiter #(.NumIn(4), .DataWidth(32), .LockIn(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_a), .req_i(req_a), .gnt_o(a_gnt_o),
        .data_i(data_ab), .req_o(a_req_o), .gnt_i(gnt_a), .data_o(a_data_o), .idx_o(a_idx_o)
    );

    rr_req_arbiter #(.NumIn(4), .DataWidth(32), .LockIn(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_b), .req_i(req_b), .gnt_o(b_gnt_o),
        .data_i(data_ab), .req_o(b_req_o), .gnt_i(gnt_b), .data_o(b_data_o), .idx_o(b_idx_o)
    );

    rr_req_arbiter #(.NumIn(3), .DataWidth(32), .LockIn(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_c), .req_i(req_c), .gnt_o(c_gnt_o),
        .data_i(data_c), .req_o(c_req_o), .gnt_i(gnt_c), .data_o(c_data_o), .idx_o(c_idx_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {req_o, idx_o, gnt_o, data_o} for a 4-input instance with a live request.
    function automatic logic [38:0] ev4(input int idx, input bit g);
        logic [3:0] gv;
        gv = g ? (4'b0001 << idx) : 4'b0000;
        return {1'b1, 2'(idx), gv, 32'hC0DE_0000 + 32'(idx)};
    endfunction

    function automatic logic [36:0] ev3(input int idx, input bit g);
        logic [2:0] gv;
        gv = g ? (3'b001 << idx) : 3'b000;
        return {1'b1, 2'(idx), gv, 32'hC0DE_0000 + 32'(idx)};
    endfunction

    task automatic test_reset();
        logic [38:0] got;
        rst_n = 1'b0;
        req_a = 4'b0000;
        gnt_a = 1'b1;
        #1;
        got = {a_req_o, a_idx_o, a_gnt_o, a_data_o};
        total_cnt++;
        if (got !== 39'd0) $display("FAIL reset_in: got %h expected %h", got, 39'd0);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            got = {a_req_o, a_idx_o, a_gnt_o, a_data_o};
            total_cnt++;
            if (got !== 39'd0) $display("FAIL reset_idle[%0d]: got %h expected %h", k, got, 39'd0);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rotation();
        logic [38:0] got, expv;
        req_a = 4'b1111;
        gnt_a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got  = {a_req_o, a_idx_o, a_gnt_o, a_data_o};
            expv = ev4(k % 4, 1'b1);
            total_cnt++;
            if (got !== expv) $display("FAIL rotation[%0d]: got %h expected %h", k, got, expv);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  rq [3] = '{4'b0100, 4'b1001, 4'b1001};
        int          ex [3] = '{2, 3, 0};
        logic [38:0] got, expv;
        gnt_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_a = rq[k];
            @(negedge clk);
            got  = {a_req_o, a_idx_o, a_gnt_o, a_data_o};
            expv = ev4(ex[k], 1'b1);
            total_cnt++;
            if (got !== expv) $display("FAIL wrap[%0d]: got %h expected %h", k, got, expv);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    // Enters with rr_q=1; second half locks on 1 while input 0 would win an unlocked search.
    task automatic test_lock();
        logic [3:0]  rq [10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0110,
                                 4'b0100, 4'b0010, 4'b0011, 4'b0011, 4'b0001};
        bit          gn [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
        int          ex [10] = '{1, 1, 1, 1, 1, 2, 1, 1, 1, 0};
        logic [38:0] got, expv;
        for (int k = 0; k < 10; k++) begin
            req_a = rq[k];
            gnt_a = gn[k];
            @(negedge clk);
            got  = {a_req_o, a_idx_o, a_gnt_o, a_data_o};
            expv = ev4(ex[k], gn[k]);
            total_cnt++;
            if (got !== expv) $display("FAIL lock[%0d]: got %h expected %h", k, got, expv);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    // Enters with rr_q=1, unlocked.
    task automatic test_flush();
        logic [3:0]  rq [6] = '{4'b0100, 4'b0110, 4'b1111, 4'b1111, 4'b1111, 4'b0100};
        bit          gn [6] = '{0, 0, 0, 1, 1, 0};
        bit          fl [6] = '{0, 1, 0, 0, 1, 0};
        int          ex [6] = '{2, 2, 0, 0, 1, 2};
        logic [38:0] got, expv;
        for (int k = 0; k < 6; k++) begin
            req_a   = rq[k];
            gnt_a   = gn[k];
            flush_a = fl[k];
            @(negedge clk);
            got  = {a_req_o, a_idx_o, a_gnt_o, a_data_o};
            expv = ev4(ex[k], gn[k]);
            total_cnt++;
            if (got !== expv) $display("FAIL flush[%0d]: got %h expected %h", k, got, expv);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        flush_a = 1'b0;
        // Locked on 2 with rr_q=0: widen the request, then pulse the async reset mid-cycle.
        req_a = 4'b1111;
        gnt_a = 1'b0;
        #2;
        got = {a_req_o, a_idx_o, a_gnt_o, a_data_o};
        expv = ev4(2, 1'b0);
        total_cnt++;
        if (got !== expv) $display("FAIL locked_pre_rst: got %h expected %h", got, expv);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        got = {a_req_o, a_idx_o, a_gnt_o, a_data_o};
        expv = ev4(0, 1'b0);
        total_cnt++;
        if (got !== expv) $display("FAIL async_rst: got %h expected %h", got, expv);
        else pass_cnt++;
        rst_n = 1'b1;
        gnt_a = 1'b1;
        @(negedge clk);
        got = {a_req_o, a_idx_o, a_gnt_o, a_data_o};
        expv = ev4(0, 1'b1);
        total_cnt++;
        if (got !== expv) $display("FAIL post_rst: got %h expected %h", got, expv);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    // All four requesting with random gnt_i: no input may wait more than NumIn-1 transfers.
    task automatic test_fairness();
        int wait_cnt [4] = '{0, 0, 0, 0};
        int idx;
        req_a = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            gnt_a = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (gnt_a) begin
                idx = int'(a_idx_o);
                total_cnt++;
                if (wait_cnt[idx] > 3 || a_gnt_o !== (4'b0001 << idx))
                    $display("FAIL fair[%0d]: idx %0d waited %0d gnt_o %b", k, idx, wait_cnt[idx], a_gnt_o);
                else pass_cnt++;
                for (int j = 0; j < 4; j++) wait_cnt[j] = (j == idx) ? 0 : wait_cnt[j] + 1;
            end
            @(posedge clk); #1;
        end
        gnt_a = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 4; j++) wait_cnt[j]++;
        req_a = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            total_cnt++;
            if (wait_cnt[j] > 4) $display("FAIL fair_end[%0d]: waited %0d limit 4", j, wait_cnt[j]);
            else pass_cnt++;
        end
    endtask

    task automatic test_nolock();
        logic [3:0]  rq [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0110};
        bit          gn [6] = '{1, 0, 0, 0, 0, 1};
        int          ex [6] = '{1, 1, 1, 1, 2, 2};
        logic [38:0] got, expv;
        for (int k = 0; k < 6; k++) begin
            req_b = rq[k];
            gnt_b = gn[k];
            @(negedge clk);
            got  = {b_req_o, b_idx_o, b_gnt_o, b_data_o};
            expv = ev4(ex[k], gn[k]);
            total_cnt++;
            if (got !== expv) $display("FAIL nolock[%0d]: got %h expected %h", k, got, expv);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        req_b = 4'b0000;
    endtask

    task automatic test_num3();
        logic [2:0]  rq [6] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b011, 3'b101};
        int          ex [6] = '{0, 1, 2, 0, 1, 2};
        logic [36:0] got, expv;
        gnt_c = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_c = rq[k];
            @(negedge clk);
            got  = {c_req_o, c_idx_o, c_gnt_o, c_data_o};
            expv = ev3(ex[k], 1'b1);
            total_cnt++;
            if (got !== expv) $display("FAIL num3[%0d]: got %h expected %h", k, got, expv);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        req_c = 3'b101;
        @(negedge clk);
        got  = {c_req_o, c_idx_o, c_gnt_o, c_data_o};
        expv = ev3(0, 1'b1);
        total_cnt++;
        if (got !== expv) $display("FAIL num3_wrap: got %h expected %h", got, expv);
        else pass_cnt++;
        @(posedge clk); #1;
        req_c = 3'b000;
    endtask

    initial begin
        flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        gnt_a = 1'b0; gnt_b = 1'b0; gnt_c = 1'b0;
        for (int i = 0; i < 4; i++) data_ab[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        for (int i = 0; i < 3; i++) data_c[i*32 +: 32]  = 32'hC0DE_0000 + 32'(i);

        test_reset();
        test_rotation();
        test_wrap();
        test_lock();
        test_flush();
        test_fairness();
        test_nolock();
        test_num3();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
